// File: rtl/rv32i_types.sv
// Shared types for the instruction/data memory arbiter.
package rv32i_types;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_t;

    // The encoding doubles as the priority bit: 1 means data goes first.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and downstream memory port.
interface mem_arbiter_if;

    logic [31:0] i_addr;
    logic [3:0]  i_rmask;
    logic [31:0] i_rdata;
    logic        i_resp;

    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Arbiter side.
    modport slave (
        input  i_addr, i_rmask, d_addr, d_rmask, d_wmask, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_rmask, mem_wmask, mem_wdata
    );

    // Requester and memory side.
    modport master (
        output i_addr, i_rmask, d_addr, d_rmask, d_wmask, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_rmask, mem_wmask, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one memory port, one transaction in flight,
// round-robin priority between simultaneous requests.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter logic FIRST_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t  state_q;
    grant_t      grant_q;
    grant_t      prio_q;
    grant_t      grant_sel;
    logic [31:0] addr_q;
    logic [3:0]  rmask_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic        i_req;
    logic        d_req;

    assign i_req = bus.i_rmask != 4'h0;
    assign d_req = (bus.d_rmask | bus.d_wmask) != 4'h0;

    always_comb begin
        grant_sel = GRANT_I;
        if (d_req && (!i_req || prio_q == GRANT_D)) begin
            grant_sel = GRANT_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= GRANT_I;
            prio_q  <= grant_t'(FIRST_PRIO);
            addr_q  <= 32'h0;
            rmask_q <= 4'h0;
            wmask_q <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        state_q <= StBusy;
                        grant_q <= grant_sel;
                        if (grant_sel == GRANT_D) begin
                            addr_q  <= bus.d_addr;
                            rmask_q <= bus.d_rmask;
                            wmask_q <= bus.d_wmask;
                            wdata_q <= bus.d_wdata;
                        end else begin
                            addr_q  <= bus.i_addr;
                            rmask_q <= bus.i_rmask;
                            wmask_q <= 4'h0;
                            wdata_q <= 32'h0;
                        end
                    end
                end
                StBusy: begin
                    if (bus.mem_resp) begin
                        state_q <= StIdle;
                        prio_q  <= (grant_q == GRANT_I) ? GRANT_D : GRANT_I;
                        // Masks drop so memory sees no request while idle.
                        rmask_q <= 4'h0;
                        wmask_q <= 4'h0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rmask = rmask_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign bus.i_resp  = (state_q == StBusy) && (grant_q == GRANT_I) && bus.mem_resp;
    assign bus.d_resp  = (state_q == StBusy) && (grant_q == GRANT_D) && bus.mem_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level ownership model checked every cycle, plus directed
// literal expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.FIRST_PRIO(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns memory, what they asked for, and whose turn the next tie is.
    bit        m_busy  = 1'b0;
    bit        m_owner = 1'b0;   // 0 instruction, 1 data
    bit        m_turn  = 1'b1;   // winner of the next tie
    bit [31:0] m_addr  = '0;
    bit [3:0]  m_rm    = '0;
    bit [3:0]  m_wm    = '0;
    bit [31:0] m_wd    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_turn <= 1'b1;
        end else if (!m_busy) begin
            bit want_i, want_d, who;
            want_i = bus.i_rmask != 0;
            want_d = (bus.d_rmask | bus.d_wmask) != 0;
            if (want_i || want_d) begin
                who = (want_i && want_d) ? m_turn : want_d;
                m_busy  <= 1'b1;
                m_owner <= who;
                m_addr  <= who ? bus.d_addr : bus.i_addr;
                m_rm    <= who ? bus.d_rmask : bus.i_rmask;
                m_wm    <= who ? bus.d_wmask : 4'h0;
                m_wd    <= who ? bus.d_wdata : 32'h0;
            end
        end else if (bus.mem_resp) begin
            m_busy <= 1'b0;
            m_turn <= ~m_owner;
        end
    end

    always @(negedge clk) begin
        check("cyc mem_rmask", {28'h0, bus.mem_rmask}, {28'h0, (m_busy ? m_rm : 4'h0)});
        check("cyc mem_wmask", {28'h0, bus.mem_wmask}, {28'h0, (m_busy ? m_wm : 4'h0)});
        if (m_busy) begin
            check("cyc mem_addr", bus.mem_addr, m_addr);
            check("cyc mem_wdata", bus.mem_wdata, m_wd);
        end
        check("cyc i_resp", {31'h0, bus.i_resp}, {31'h0, m_busy && !m_owner && bus.mem_resp});
        check("cyc d_resp", {31'h0, bus.d_resp}, {31'h0, m_busy && m_owner && bus.mem_resp});
        check("cyc i_rdata", bus.i_rdata, bus.mem_rdata);
        check("cyc d_rdata", bus.d_rdata, bus.mem_rdata);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_resp(input logic [31:0] rdata);
        bus.mem_rdata = rdata;
        bus.mem_resp  = 1'b1;
        #1;
    endtask

    initial begin
        bus.i_addr = '0; bus.i_rmask = '0;
        bus.d_addr = '0; bus.d_rmask = '0; bus.d_wmask = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        #2 rst = 1'b1;
        step(2);
        check("rst mem_rmask", {28'h0, bus.mem_rmask}, 32'h0);
        check("rst mem_wmask", {28'h0, bus.mem_wmask}, 32'h0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_wdata", bus.mem_wdata, 32'h0);
        check("rst resp", {30'h0, bus.i_resp, bus.d_resp}, 32'h0);
        rst = 1'b0;
        step(1);

        // Lone instruction fetch.
        bus.i_addr = 32'h1eceb000; bus.i_rmask = 4'hF;
        step(1);
        check("ifetch mem_rmask", {28'h0, bus.mem_rmask}, 32'hF);
        check("ifetch mem_addr", bus.mem_addr, 32'h1eceb000);
        pulse_resp(32'h00000013);
        check("ifetch i_resp", {31'h0, bus.i_resp}, 32'h1);
        check("ifetch i_rdata", bus.i_rdata, 32'h00000013);
        check("ifetch d_resp", {31'h0, bus.d_resp}, 32'h0);
        step(1);
        bus.mem_resp = 1'b0; bus.i_rmask = 4'h0;
        step(1);

        // First tie goes to data; the re-contest right after goes to instruction.
        bus.d_addr = 32'h1eceb020; bus.d_rmask = 4'hF;
        bus.i_addr = 32'h1eceb100; bus.i_rmask = 4'hF;
        step(1);
        check("tie1 mem_addr", bus.mem_addr, 32'h1eceb020);
        pulse_resp(32'h11111111);
        check("tie1 d_resp", {31'h0, bus.d_resp}, 32'h1);
        check("tie1 i_resp", {31'h0, bus.i_resp}, 32'h0);
        step(1);
        bus.mem_resp = 1'b0; bus.d_addr = 32'h1eceb024;
        step(1);
        check("tie2 mem_addr", bus.mem_addr, 32'h1eceb100);
        pulse_resp(32'h22222222);
        check("tie2 i_resp", {31'h0, bus.i_resp}, 32'h1);
        step(1);
        bus.mem_resp = 1'b0; bus.i_rmask = 4'h0;
        step(1);
        check("tie2 data next", bus.mem_addr, 32'h1eceb024);
        pulse_resp(32'h33333333);
        step(1);
        bus.mem_resp = 1'b0; bus.d_rmask = 4'h0;
        step(1);

        // Byte write held across stalls; instruction request arriving mid-transaction waits.
        bus.d_addr = 32'h1eceb010; bus.d_wmask = 4'b0100; bus.d_wdata = 32'h00AB0000;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("stall mem_wmask", {28'h0, bus.mem_wmask}, 32'h4);
            check("stall mem_addr", bus.mem_addr, 32'h1eceb010);
            check("stall mem_wdata", bus.mem_wdata, 32'h00AB0000);
            check("stall i_resp", {31'h0, bus.i_resp}, 32'h0);
            if (i == 1) begin
                bus.i_addr = 32'h1eceb200; bus.i_rmask = 4'hF;
            end
            step(1);
        end
        pulse_resp(32'h0);
        check("wr d_resp", {31'h0, bus.d_resp}, 32'h1);
        check("wr i_resp", {31'h0, bus.i_resp}, 32'h0);
        check("wr mem_addr", bus.mem_addr, 32'h1eceb010);
        step(1);
        bus.mem_resp = 1'b0; bus.d_wmask = 4'h0;
        #1 check("wr d_resp one cycle", {31'h0, bus.d_resp}, 32'h0);
        step(1);
        check("late ifetch mem_addr", bus.mem_addr, 32'h1eceb200);
        pulse_resp(32'h44444444);
        step(1);
        bus.mem_resp = 1'b0; bus.i_rmask = 4'h0;
        step(1);

        // Spurious completion while idle.
        pulse_resp(32'h55555555);
        check("spur i_resp", {31'h0, bus.i_resp}, 32'h0);
        check("spur d_resp", {31'h0, bus.d_resp}, 32'h0);
        step(1);
        bus.mem_resp = 1'b0;
        check("spur mem_rmask", {28'h0, bus.mem_rmask}, 32'h0);

        // Read and write masks together pass through untouched.
        bus.d_addr = 32'h1eceb030; bus.d_rmask = 4'h3; bus.d_wmask = 4'hC;
        bus.d_wdata = 32'h12345678;
        step(1);
        check("rw mem_rmask", {28'h0, bus.mem_rmask}, 32'h3);
        check("rw mem_wmask", {28'h0, bus.mem_wmask}, 32'hC);
        pulse_resp(32'h66666666);
        step(1);
        bus.mem_resp = 1'b0; bus.d_rmask = 4'h0; bus.d_wmask = 4'h0;
        step(1);

        // Reset mid-transaction; priority must return to data.
        bus.i_addr = 32'h1eceb300; bus.i_rmask = 4'hF;
        step(2);
        rst = 1'b1;
        #1;
        check("rst busy mem_rmask", {28'h0, bus.mem_rmask}, 32'h0);
        check("rst busy mem_addr", bus.mem_addr, 32'h0);
        check("rst busy mem_wdata", bus.mem_wdata, 32'h0);
        pulse_resp(32'h77777777);
        check("rst busy resp", {30'h0, bus.i_resp, bus.d_resp}, 32'h0);
        step(1);
        bus.mem_resp = 1'b0;
        step(1);
        rst = 1'b0;
        bus.d_addr = 32'h1eceb040; bus.d_rmask = 4'hF;
        step(1);
        check("post-rst tie mem_addr", bus.mem_addr, 32'h1eceb040);
        pulse_resp(32'h88888888);
        check("post-rst d_resp", {31'h0, bus.d_resp}, 32'h1);
        step(1);
        bus.mem_resp = 1'b0; bus.d_rmask = 4'h0; bus.i_rmask = 4'h0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIRST_PRIO, default 1'b1, requester that wins the first simultaneous contest after reset (1 = data, 0 = instruction).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 i_addr  input  32  instruction-fetch byte address, word aligned.
REQ-005 i_rmask  input  4  instruction read mask; nonzero = request.
REQ-006 i_rdata  output  32  instruction read data.
REQ-007 i_resp  output  1  instruction transaction complete.
REQ-008 d_addr  input  32  data address, bits [1:0] = 0.
REQ-009 d_rmask  input  4  data read byte mask.
REQ-010 d_wmask  input  4  data write byte mask; request = (d_rmask|d_wmask) != 0.
REQ-011 d_wdata  input  32  data write data, lane-aligned.
REQ-012 d_rdata  output  32  data read data.
REQ-013 d_resp  output  1  data transaction complete.
REQ-014 mem_addr, mem_rmask, mem_wmask, mem_wdata  output  32/4/4/32  downstream memory request.
REQ-015 mem_rdata  input  32  downstream read data.
REQ-016 mem_resp  input  1  downstream completion, one-cycle pulse.

Function
REQ-017 FSM states: IDLE, BUSY; exactly one transaction outstanding downstream.
REQ-018 IDLE, no request: stay IDLE, all mem_* masks 0.
REQ-019 IDLE, one requester active: grant it, register addr/masks/wdata, go BUSY next edge.
REQ-020 IDLE, both active: grant the requester indicated by prio bit; other waits.
REQ-021 Downstream outputs are registered: mem_* driven from captured fields for every BUSY cycle, unchanged until mem_resp.
REQ-022 Minimum latency: request visible cycle N, mem_* valid cycle N+1, requester resp same cycle as mem_resp (combinational forward).
REQ-023 BUSY with mem_resp=1: assert resp to granted requester only, that cycle; return to IDLE next edge; set prio to the non-granted requester (round-robin).
REQ-024 BUSY with mem_resp=0: hold all state; new requester inputs ignored.
REQ-025 i_rdata and d_rdata both equal mem_rdata at all times; only resp qualifies them.
REQ-026 mem_resp in IDLE is ignored; no resp forwarded; no state change.
REQ-027 Requester holds inputs stable until its resp; a request present in the cycle after its resp is a new transaction.
REQ-028 Data request with both rmask and wmask nonzero forwarded unmodified; no arbitration error.
REQ-029 Starvation bound: a waiting requester is granted within one foreign transaction.
REQ-030 Idle-cycle overhead: one IDLE cycle between back-to-back transactions.

Reset
REQ-031 On rst: state=IDLE, prio=FIRST_PRIO, captured fields 0, mem_rmask=mem_wmask=0, mem_addr=mem_wdata=0, i_resp=d_resp=0.
REQ-032 Reset mid-BUSY abandons the transaction; no resp issued; downstream memory reset with same rst.

Structure
REQ-033 Arbiter state enum and grant-id typedef (GRANT_I, GRANT_D) in shared package rv32i_types.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 i_rmask=4'hF, i_addr=32'h1eceb000 alone -> mem_rmask=4'hF, mem_addr=32'h1eceb000 at N+1; mem_resp with rdata 32'h00000013 -> i_resp=1, i_rdata=32'h00000013, d_resp=0.
REQ-036 Both request at same cycle after reset (FIRST_PRIO=1) -> data granted first, instruction granted next IDLE; a second contest grants instruction.
REQ-037 d_wmask=4'b0100, d_wdata=32'h00AB0000, d_addr=32'h1eceb010 -> identical mem_* values held over 5 stall cycles until mem_resp; d_resp exactly one cycle.
REQ-038 Change i_addr during data BUSY -> mem_addr unchanged; i_resp stays 0.
REQ-039 Spurious mem_resp in IDLE -> no resp on either side; state remains IDLE.
REQ-040 Assert rst during BUSY, then mem_resp -> all outputs 0 immediately, no resp, prio=FIRST_PRIO.
